// File: rtl/mips32_multicycle.sv
// mips32_multicycle: multi-cycle MIPS32 core; one shared ALU, handshaked instruction fetch, internal data memory
module mips32_multicycle #(
   parameter int DMEM_ADDR_BITS = 7,
   parameter int IMEM_ADDR_BITS = 8,
   parameter int RESULT_REG = 2,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                      clock,
   input  logic                      reset,
   output logic                      imem_req,
   output logic [IMEM_ADDR_BITS-1:0] imem_addr,
   input  logic                      imem_valid,
   input  logic [31:0]               imem_data,
   output logic                      halted,
   output logic [31:0]               result,
   output logic [31:0]               retired
);
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   localparam logic [4:0] RES_IDX = 5'(RESULT_REG);
   state_t state;
   logic [31:0] pc, ir, a, b, aluout, mdr, alu, imm, pc4;
   logic [31:0] regs [32];
   logic [31:0] dmem [2**DMEM_ADDR_BITS];
   logic [5:0] op, funct;
   logic [4:0] rs, rt, rd, shamt, dst;
   logic [DMEM_ADDR_BITS-1:0] daddr;
   logic alu_ok, is_lw, is_sw, is_branch, is_jump, taken;
   assign op = ir[31:26];
   assign rs = ir[25:21];
   assign rt = ir[20:16];
   assign rd = ir[15:11];
   assign shamt = ir[10:6];
   assign funct = ir[5:0];
   assign imm = (op == 6'd12 || op == 6'd13 || op == 6'd14) ? {16'd0, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
   assign pc4 = pc + 32'd4;
   assign is_lw = op == 6'd35;
   assign is_sw = op == 6'd43;
   assign is_branch = op == 6'd4 || op == 6'd5;
   assign is_jump = op == 6'd2 || op == 6'd3;
   assign taken = op[0] ? a != b : a == b;
   assign dst = op == 6'd0 ? rd : rt;
   assign daddr = aluout[DMEM_ADDR_BITS+1:2];
   assign imem_req = state == FETCH && !reset;
   assign imem_addr = pc[IMEM_ADDR_BITS+1:2];
   assign result = RES_IDX == 5'd0 ? 32'd0 : regs[RES_IDX];
   // Shared ALU; alu_ok is low for anything that is not a register-writing or memory op
   always_comb begin
      alu = 32'd0;
      alu_ok = 1'b1;
      if (op == 6'd0)
         case (funct)
            6'd0: alu = b << shamt;
            6'd2: alu = b >> shamt;
            6'd3: alu = $signed(b) >>> shamt;
            6'd6: alu = b >> a[4:0];
            6'd7: alu = $signed(b) >>> a[4:0];
            6'd32: alu = a + b;
            6'd34: alu = a - b;
            6'd36: alu = a & b;
            6'd37: alu = a | b;
            6'd38: alu = a ^ b;
            6'd39: alu = ~(a | b);
            6'd42: alu = {31'd0, $signed(a) < $signed(b)};
            default: alu_ok = 1'b0;
         endcase
      else
         case (op)
            6'd8, 6'd35, 6'd43: alu = a + imm;
            6'd10: alu = {31'd0, $signed(a) < $signed(imm)};
            6'd12: alu = a & imm;
            6'd13: alu = a | imm;
            6'd14: alu = a ^ imm;
            6'd15: alu = {ir[15:0], 16'd0};
            default: alu_ok = 1'b0;
         endcase
   end
   // Phase sequencing and datapath latches; reset aborts whatever is in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= FETCH;
         pc <= RESET_PC;
         retired <= 32'd0;
         halted <= 1'b0;
      end else
         case (state)
            FETCH: if (imem_valid) begin
               ir <= imem_data;
               state <= DECODE;
            end
            DECODE: begin
               a <= rs == 5'd0 ? 32'd0 : regs[rs];
               b <= rt == 5'd0 ? 32'd0 : regs[rt];
               state <= (op == 6'd0 && funct == 6'd13) ? HALT : EXEC;
               halted <= op == 6'd0 && funct == 6'd13;
            end
            EXEC: begin
               aluout <= alu;
               if (is_branch || is_jump || !alu_ok) begin
                  pc <= is_jump ? {pc4[31:28], ir[25:0], 2'b00} : (is_branch && taken) ? pc4 + {imm[29:0], 2'b00} : pc4;
                  retired <= retired + 32'd1;
                  state <= FETCH;
               end else
                  state <= (is_lw || is_sw) ? MEM : WB;
            end
            MEM: begin
               mdr <= dmem[daddr];
               if (is_sw) begin
                  pc <= pc4;
                  retired <= retired + 32'd1;
                  state <= FETCH;
               end else
                  state <= WB;
            end
            WB: begin
               pc <= pc4;
               retired <= retired + 32'd1;
               state <= FETCH;
            end
            default: state <= HALT;
         endcase
   end
   // Architectural commits: jal link, write-back and store; never while reset is asserted
   always_ff @(posedge clock) begin
      if (!reset && state == EXEC && op == 6'd3)
         regs[31] <= pc4;
      if (!reset && state == WB && dst != 5'd0)
         regs[dst] <= is_lw ? mdr : aluout;
      if (!reset && state == MEM && is_sw)
         dmem[daddr] <= b;
   end
endmodule

// File: tb/tb_mips32_multicycle.sv
// tb_mips32_multicycle: randomized self-checking bench against an instruction-level reference model
module tb_mips32_multicycle;
   logic clock = 1'b0, reset = 1'b1, imem_valid = 1'b0;
   logic [31:0] imem_data = 32'd0;
   logic imem_req, halted;
   logic [7:0] imem_addr;
   logic [31:0] result, retired;
   int total = 0, bad = 0;
   logic [31:0] mregs [32];
   logic [31:0] mmem [128];
   logic [31:0] mpc = 32'd0, mret = 32'd0;
   bit mhalt = 1'b0;
   int exp_lat, obs_lat;
   bit obs_stable;
   logic [31:0] prog [256];
   int fns [12] = '{0, 2, 3, 6, 7, 32, 34, 36, 37, 38, 39, 42};
   int iops [6] = '{8, 10, 12, 13, 14, 15};

   mips32_multicycle dut (
      .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_data(imem_data), .halted(halted),
      .result(result), .retired(retired)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] r_ins(input int fn, input int rs, input int rt, input int rd, input int sh);
      return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
   endfunction

   function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] j_ins(input int op, input int tgt);
      return {6'(op), 26'(tgt)};
   endfunction

   // Executes one whole instruction at ISA level; returns zero-wait latency in cycles, -1 if unspecified
   function automatic int model_exec(input logic [31:0] ins);
      logic [5:0] op, fn;
      logic [4:0] rs, rt, rd, sh;
      logic [31:0] a, b, se, ze, res, npc;
      int dst, lat, widx;
      op = ins[31:26]; fn = ins[5:0]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; sh = ins[10:6];
      a = mregs[rs]; b = mregs[rt];
      se = int'($signed(ins[15:0]));
      ze = {16'd0, ins[15:0]};
      npc = mpc + 32'd4;
      widx = int'(((a + se) >> 2) % 128);
      dst = -1; res = 32'd0; lat = 4;
      case (op)
         0: begin
            dst = rd;
            case (fn)
               0: res = b << sh;
               2: res = b >> sh;
               3: res = $signed(b) >>> sh;
               6: res = b >> a[4:0];
               7: res = $signed(b) >>> a[4:0];
               32: res = a + b;
               34: res = a - b;
               36: res = a & b;
               37: res = a | b;
               38: res = a ^ b;
               39: res = ~(a | b);
               42: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
               13: begin mhalt = 1'b1; return 2; end
               default: begin dst = -1; lat = -1; end
            endcase
         end
         2, 3: begin
            if (op == 3) mregs[31] = npc;
            npc = {npc[31:28], ins[25:0], 2'b00};
            lat = 3;
         end
         4: begin if (a == b) npc = npc + se * 4; lat = 3; end
         5: begin if (a != b) npc = npc + se * 4; lat = 3; end
         8: begin res = a + se; dst = rt; end
         10: begin res = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; dst = rt; end
         12: begin res = a & ze; dst = rt; end
         13: begin res = a | ze; dst = rt; end
         14: begin res = a ^ ze; dst = rt; end
         15: begin res = ze << 16; dst = rt; end
         35: begin res = mmem[widx]; dst = rt; lat = 5; end
         43: mmem[widx] = b;
         default: lat = -1;
      endcase
      if (dst > 0) mregs[dst] = res;
      mpc = npc;
      mret = mret + 32'd1;
      return lat;
   endfunction

   // Drives one fetch with the given wait states and measures cycles until the next fetch or halt
   task automatic run_instr(input logic [31:0] ins, input int waits, output int lat, output bit stable);
      logic [7:0] a0;
      logic [31:0] r0, t0;
      int n;
      stable = 1'b1; lat = 0; n = 0;
      imem_valid = 1'b0;
      while (!imem_req && n < 20) begin @(posedge clock); #1; n++; end
      a0 = imem_addr; r0 = result; t0 = retired;
      for (int i = 0; i < waits; i++) begin
         imem_valid = 1'b0; imem_data = $urandom;
         @(posedge clock); #1; lat++;
         if (imem_addr !== a0 || imem_req !== 1'b1 || result !== r0 || retired !== t0) stable = 1'b0;
      end
      imem_valid = 1'b1; imem_data = ins;
      @(posedge clock); #1; lat++; n = 0;
      while (!imem_req && !halted && n < 20) begin
         imem_valid = 1'($urandom_range(0, 1)); imem_data = $urandom;
         @(posedge clock); #1; lat++; n++;
      end
      imem_valid = 1'b0;
   endtask

   task automatic issue(input logic [31:0] ins, input int waits);
      int l;
      run_instr(ins, waits, obs_lat, obs_stable);
      l = model_exec(ins);
      exp_lat = l < 0 ? -1 : l + waits;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1; imem_valid = 1'b0;
      repeat (n) begin @(posedge clock); #1; end
      reset = 1'b0; #1;
      mpc = 32'd0; mret = 32'd0; mhalt = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; imem_valid = 1'b0;
      repeat (3) begin @(posedge clock); #1; end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b want=0", halted); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem_req); end
      total++; if (retired !== 32'd0) begin bad++; $display("FAIL reset_retired got=%0d want=0", retired); end
      reset = 1'b0; #1;
      mpc = 32'd0; mret = 32'd0; mhalt = 1'b0;
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b want=1", imem_req); end
      total++; if (imem_addr !== 8'd0) begin bad++; $display("FAIL first_addr got=%h want=00", imem_addr); end
   endtask

   task automatic test_alu();
      issue(i_ins(8, 0, 2, -5), 0);
      total++; if (result !== 32'hFFFFFFFB) begin bad++; $display("FAIL addi_res got=%h want=fffffffb", result); end
      total++; if (retired !== 32'd1) begin bad++; $display("FAIL addi_retired got=%0d want=1", retired); end
      total++; if (obs_lat !== 4) begin bad++; $display("FAIL addi_lat got=%0d want=4", obs_lat); end
      issue(r_ins(3, 0, 2, 2, 1), 0);
      total++; if (result !== 32'hFFFFFFFD) begin bad++; $display("FAIL sra_res got=%h want=fffffffd", result); end
      issue(i_ins(10, 2, 2, 0), 0);
      total++; if (result !== 32'd1) begin bad++; $display("FAIL slti_res got=%h want=1", result); end
      total++; if (imem_addr !== 8'd3) begin bad++; $display("FAIL alu_pc got=%h want=03", imem_addr); end
   endtask

   task automatic test_fetch_wait();
      issue(i_ins(8, 2, 2, 6), 3);
      total++; if (obs_lat !== 7) begin bad++; $display("FAIL wait_lat got=%0d want=7", obs_lat); end
      total++; if (obs_stable !== 1'b1) begin bad++; $display("FAIL wait_stable got=%b want=1", obs_stable); end
      total++; if (result !== 32'd7) begin bad++; $display("FAIL wait_res got=%h want=7", result); end
      total++; if (retired !== mret) begin bad++; $display("FAIL wait_retired got=%0d want=%0d", retired, mret); end
   endtask

   task automatic test_memory();
      issue(i_ins(8, 0, 2, 'h1234), 0);
      issue(i_ins(43, 0, 2, 4), 0);
      total++; if (obs_lat !== 4) begin bad++; $display("FAIL sw_lat got=%0d want=4", obs_lat); end
      issue(i_ins(35, 0, 3, 4), 0);
      total++; if (obs_lat !== 5) begin bad++; $display("FAIL lw_lat got=%0d want=5", obs_lat); end
      issue(r_ins(37, 3, 0, 2, 0), 0);
      total++; if (result !== 32'h1234) begin bad++; $display("FAIL lw_res got=%h want=1234", result); end
      issue(i_ins(8, 0, 0, 7), 0);
      issue(r_ins(37, 0, 0, 2, 0), 0);
      total++; if (result !== 32'd0) begin bad++; $display("FAIL zero_reg got=%h want=0", result); end
      issue(i_ins(8, 0, 2, 'h7777), 0);
      issue(i_ins(43, 0, 2, 4 + (1 << 9)), 0);
      issue(i_ins(35, 0, 3, 4), 0);
      issue(r_ins(32, 3, 0, 2, 0), 0);
      total++; if (result !== 32'h7777) begin bad++; $display("FAIL alias_res got=%h want=7777", result); end
      total++; if (retired !== mret) begin bad++; $display("FAIL mem_retired got=%0d want=%0d", retired, mret); end
   endtask

   task automatic test_control();
      logic [31:0] p, r;
      logic [7:0] pa;
      issue(i_ins(8, 0, 5, 3), 0);
      issue(i_ins(8, 0, 6, 3), 0);
      issue(i_ins(8, 0, 7, 4), 0);
      p = mpc; issue(i_ins(4, 5, 6, 2), 0);
      total++; if (imem_addr !== 8'((p + 12) >> 2)) begin bad++; $display("FAIL beq_taken got=%h want=%h", imem_addr, 8'((p + 12) >> 2)); end
      total++; if (obs_lat !== 3) begin bad++; $display("FAIL beq_lat got=%0d want=3", obs_lat); end
      p = mpc; issue(i_ins(4, 5, 7, 2), 0);
      total++; if (imem_addr !== 8'((p + 4) >> 2)) begin bad++; $display("FAIL beq_not got=%h want=%h", imem_addr, 8'((p + 4) >> 2)); end
      p = mpc; issue(i_ins(5, 5, 7, -2), 0);
      total++; if (imem_addr !== 8'((p - 4) >> 2)) begin bad++; $display("FAIL bne_taken got=%h want=%h", imem_addr, 8'((p - 4) >> 2)); end
      p = mpc; issue(i_ins(5, 5, 6, 5), 0);
      total++; if (imem_addr !== 8'((p + 4) >> 2)) begin bad++; $display("FAIL bne_not got=%h want=%h", imem_addr, 8'((p + 4) >> 2)); end
      do_reset(1);
      repeat (4) issue(i_ins(8, 0, 0, 0), 0);
      total++; if (imem_addr !== 8'h04) begin bad++; $display("FAIL pre_jal_pc got=%h want=04", imem_addr); end
      issue(j_ins(3, 'h40), 0);
      total++; if (imem_addr !== 8'h40) begin bad++; $display("FAIL jal_pc got=%h want=40", imem_addr); end
      total++; if (obs_lat !== 3) begin bad++; $display("FAIL jal_lat got=%0d want=3", obs_lat); end
      issue(r_ins(37, 31, 0, 2, 0), 0);
      total++; if (result !== 32'h14) begin bad++; $display("FAIL jal_link got=%h want=14", result); end
      r = result; pa = imem_addr;
      issue(32'hFC42_1234, 0);
      issue(r_ins(1, 1, 1, 2, 0), 0);
      total++; if (result !== r) begin bad++; $display("FAIL unknown_nowrite got=%h want=%h", result, r); end
      total++; if (imem_addr !== pa + 8'd2) begin bad++; $display("FAIL unknown_pc got=%h want=%h", imem_addr, pa + 8'd2); end
      total++; if (retired !== mret) begin bad++; $display("FAIL unknown_retired got=%0d want=%0d", retired, mret); end
   endtask

   task automatic test_random();
      logic [31:0] ins;
      int k;
      for (int r = 1; r < 8; r++) begin
         issue(i_ins(15, 0, r, $urandom_range(0, 65535)), 0);
         issue(i_ins(13, r, r, $urandom_range(0, 65535)), 0);
      end
      for (int i = 0; i < 80; i++) begin
         k = $urandom_range(0, 9);
         if (k < 6) ins = r_ins(fns[$urandom_range(0, 11)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
         else if (k < 8) ins = i_ins(iops[$urandom_range(0, 5)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
         else if (k == 8) ins = i_ins($urandom_range(4, 5), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 65535));
         else ins = j_ins($urandom_range(2, 3), $urandom);
         issue(ins, $urandom_range(0, 2));
         total++; if (result !== mregs[2]) begin bad++; $display("FAIL rnd_res[%0d] ins=%h got=%h want=%h", i, ins, result, mregs[2]); end
         total++; if (imem_addr !== mpc[9:2]) begin bad++; $display("FAIL rnd_pc[%0d] ins=%h got=%h want=%h", i, ins, imem_addr, mpc[9:2]); end
         total++; if (retired !== mret) begin bad++; $display("FAIL rnd_retired[%0d] got=%0d want=%0d", i, retired, mret); end
         total++; if (obs_lat !== exp_lat) begin bad++; $display("FAIL rnd_lat[%0d] ins=%h got=%0d want=%0d", i, ins, obs_lat, exp_lat); end
      end
   endtask

   task automatic test_sum();
      int w, n;
      logic [31:0] exp_ret, exp_res, t0;
      bit req_seen;
      do_reset(2);
      for (int i = 0; i < 256; i++) prog[i] = 32'd0;
      prog[0] = i_ins(8, 0, 2, 0);
      prog[1] = i_ins(8, 0, 1, 0);
      prog[2] = i_ins(8, 0, 4, 10);
      prog[3] = r_ins(32, 2, 1, 2, 0);
      prog[4] = i_ins(8, 1, 1, 1);
      prog[5] = i_ins(5, 1, 4, -3);
      prog[6] = r_ins(13, 0, 0, 0, 0);
      n = 0;
      while (!mhalt && n < 1000) begin void'(model_exec(prog[mpc[9:2]])); n++; end
      exp_ret = mret; exp_res = mregs[2];
      w = $urandom_range(0, 2); n = 0;
      while (!halted && n < 3000) begin
         if (imem_req && w == 0) begin
            imem_valid = 1'b1; imem_data = prog[imem_addr]; w = $urandom_range(0, 2);
         end else begin
            imem_valid = imem_req ? 1'b0 : 1'($urandom_range(0, 1)); imem_data = $urandom;
            if (imem_req) w--;
         end
         @(posedge clock); #1; n++;
      end
      imem_valid = 1'b0;
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL sum_halted got=%b want=1 after %0d cycles", halted, n); end
      total++; if (result !== 32'd45) begin bad++; $display("FAIL sum_res got=%0d want=45", result); end
      total++; if (result !== exp_res) begin bad++; $display("FAIL sum_model got=%0d want=%0d", result, exp_res); end
      total++; if (retired !== exp_ret) begin bad++; $display("FAIL sum_retired got=%0d want=%0d", retired, exp_ret); end
      t0 = retired; req_seen = 1'b0;
      repeat (20) begin
         imem_valid = 1'($urandom_range(0, 1)); imem_data = $urandom;
         @(posedge clock); #1;
         if (imem_req !== 1'b0) req_seen = 1'b1;
      end
      imem_valid = 1'b0;
      total++; if (req_seen !== 1'b0) begin bad++; $display("FAIL halt_req got=1 want=0"); end
      total++; if (retired !== t0) begin bad++; $display("FAIL halt_retired got=%0d want=%0d", retired, t0); end
      total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_stays got=%b want=1", halted); end
   endtask

   task automatic test_reset_wb();
      do_reset(1);
      imem_valid = 1'b1; imem_data = i_ins(8, 0, 2, 99);
      @(posedge clock); #1;
      imem_valid = 1'b0;
      repeat (2) begin @(posedge clock); #1; end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0; #1;
      mpc = 32'd0; mret = 32'd0; mhalt = 1'b0;
      total++; if (result !== mregs[2]) begin bad++; $display("FAIL rstwb_res got=%h want=%h", result, mregs[2]); end
      total++; if (retired !== 32'd0) begin bad++; $display("FAIL rstwb_retired got=%0d want=0", retired); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin bad++; $display("FAIL rstwb_restart got=%b/%h want=1/00", imem_req, imem_addr); end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL rstwb_halted got=%b want=0", halted); end
      issue(i_ins(8, 2, 2, 1), 1);
      total++; if (result !== 32'd46) begin bad++; $display("FAIL rstwb_after got=%0d want=46", result); end
      total++; if (retired !== 32'd1) begin bad++; $display("FAIL rstwb_after_ret got=%0d want=1", retired); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      for (int i = 0; i < 128; i++) mmem[i] = 32'd0;
      test_reset();
      test_alu();
      test_fetch_wait();
      test_memory();
      test_control();
      test_random();
      test_sum();
      test_reset_wb();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
